// File: rtl/lsu_pkg.sv
// Shared types and beat-planning helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    // The 2'b11 size encoding is treated as a word.
    function automatic size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

    // Only an aligned word maps onto a native word access; everything else is byte-serial.
    function automatic logic [2:0] beat_count(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return (addr_lo == 2'b00) ? 3'd1 : 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of an assembled load word according to access size.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic [1:0]            size,
    input  logic                  zero_extend,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] result
);

    logic byte_sign;
    logic half_sign;

    always_comb begin
        byte_sign = ~zero_extend & data[BYTE_WIDTH-1];
        half_sign = ~zero_extend & data[2*BYTE_WIDTH-1];
        case (size_e'(size))
            SIZE_BYTE: result = {{(DATA_WIDTH-BYTE_WIDTH){byte_sign}}, data[BYTE_WIDTH-1:0]};
            SIZE_HALF: result = {{(DATA_WIDTH-2*BYTE_WIDTH){half_sign}}, data[2*BYTE_WIDTH-1:0]};
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word/byte data memory; sub-word and misaligned accesses become byte beats.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses complete with resp_err_o and no memory beat.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_op_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);

    localparam int unsigned LANES = DATA_WIDTH / BYTE_WIDTH;

    state_e                state;
    state_e                state_next;

    logic                  req_we_q;
    size_e                 req_size_q;
    logic                  req_unsigned_q;
    logic [DATA_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic                  word_q;
    logic [2:0]            beats_q;
    logic [1:0]            beat_q;
    logic [DATA_WIDTH-1:0] assembly_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    size_e                 req_size;
    logic                  misaligned;
    logic                  trap;
    logic                  accept;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] extended;

    always_comb begin
        req_size   = decode_size(req_size_i);
        misaligned = is_misaligned(req_size, req_addr_i[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        trap       = misaligned;
`else
        trap       = 1'b0;
`endif
        accept     = (state == IDLE) && req_valid_i;
        last_beat  = ({1'b0, beat_q} == (beats_q - 3'd1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = trap ? DONE : ACCESS;
            ACCESS:  if (last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_we_o      = 1'b0;
        mem_byte_op_o = 1'b0;
        mem_addr_o    = '0;
        mem_wd_o      = '0;
        if (state == ACCESS) begin
            mem_we_o      = req_we_q;
            mem_byte_op_o = ~word_q;
            mem_addr_o    = word_q ? req_addr_q : req_addr_q + DATA_WIDTH'(beat_q);
            if (req_we_q) begin
                if (word_q) begin
                    mem_wd_o = req_wdata_q;
                end else begin
                    for (int unsigned lane = 0; lane < LANES; lane++) begin
                        if (beat_q == lane[1:0])
                            mem_wd_o[BYTE_WIDTH-1:0] = req_wdata_q[lane*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // The final beat's byte is merged before extension so the result registers on the DONE-entry edge.
    always_comb begin
        merged = assembly_q;
        if (word_q) begin
            merged = mem_rd_i;
        end else begin
            for (int unsigned lane = 0; lane < LANES; lane++) begin
                if (beat_q == lane[1:0])
                    merged[lane*BYTE_WIDTH +: BYTE_WIDTH] = mem_rd_i[BYTE_WIDTH-1:0];
            end
        end
    end

    lsu_load_extend #(
        .DATA_WIDTH(DATA_WIDTH),
        .BYTE_WIDTH(BYTE_WIDTH)
    ) u_load_extend (
        .size        (req_size_q),
        .zero_extend (req_unsigned_q),
        .data        (merged),
        .result      (extended)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            req_we_q       <= 1'b0;
            req_size_q     <= SIZE_BYTE;
            req_unsigned_q <= 1'b0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            word_q         <= 1'b0;
            beats_q        <= '0;
            beat_q         <= '0;
            assembly_q     <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_we_q       <= req_we_i;
                        req_size_q     <= req_size;
                        req_unsigned_q <= req_unsigned_i;
                        req_addr_q     <= req_addr_i;
                        req_wdata_q    <= req_wdata_i;
                        word_q         <= (req_size == SIZE_WORD) && !misaligned;
                        beats_q        <= beat_count(req_size, req_addr_i[1:0]);
                        beat_q         <= '0;
                        assembly_q     <= '0;
                        err_q          <= trap;
                        if (trap) rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    beat_q <= beat_q + 2'd1;
                    if (!req_we_q) assembly_q <= merged;
                    if (last_beat) rdata_q <= req_we_q ? '0 : extended;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = (state == DONE);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios then random traffic against a byte-level reference model.
// Follows LSU_MISALIGN_TRAP_EN when defined so expectations match the DUT build.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic        mem_byte_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .DATA_WIDTH(32),
        .BYTE_WIDTH(8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .mem_we_o       (mem_we),
        .mem_byte_op_o  (mem_byte_op),
        .mem_addr_o     (mem_addr),
        .mem_wd_o       (mem_wd),
        .mem_rd_i       (mem_rd)
    );

    // 512-byte data memory, aliased on address bits [8:0]; writes commit on negedge.
    logic [7:0] mem [512] = '{default: 8'h00};
    logic [7:0] ref_mem [512] = '{default: 8'h00};

    always_comb begin
        mem_rd = '0;
        if (mem_byte_op) mem_rd[7:0] = mem[mem_addr[8:0]];
        else mem_rd = {mem[{mem_addr[8:2], 2'b11}], mem[{mem_addr[8:2], 2'b10}],
                       mem[{mem_addr[8:2], 2'b01}], mem[{mem_addr[8:2], 2'b00}]};
    end

    always @(negedge clk) begin
        if (mem_we) begin
            if (mem_byte_op) begin
                mem[mem_addr[8:0]] <= mem_wd[7:0];
            end else begin
                mem[{mem_addr[8:2], 2'b00}] <= mem_wd[7:0];
                mem[{mem_addr[8:2], 2'b01}] <= mem_wd[15:8];
                mem[{mem_addr[8:2], 2'b10}] <= mem_wd[23:16];
                mem[{mem_addr[8:2], 2'b11}] <= mem_wd[31:24];
            end
        end
    end

    typedef struct packed {
        logic [31:0] addr;
        logic        byte_op;
        logic [31:0] wd;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] last_rdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plan beats and compute the response from byte-addressed memory contents.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned nbytes;
        logic        mis;
        logic [31:0] val;
        logic [31:0] a;
        beat_t       b;
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        mis = (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'b00);
        exp_beats.delete();
        exp_err = 1'b0;
        exp_rdata = '0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) begin
            exp_err = 1'b1;
            return;
        end
`endif
        if (nbytes == 4 && !mis) begin
            b.addr = addr; b.byte_op = 1'b0; b.wd = wdata;
            exp_beats.push_back(b);
        end else begin
            for (int k = 0; k < int'(nbytes); k++) begin
                b.addr = addr + 32'(k); b.byte_op = 1'b1; b.wd = 32'(wdata[8*k +: 8]);
                exp_beats.push_back(b);
            end
        end
        val = '0;
        for (int k = 0; k < int'(nbytes); k++) begin
            a = addr + 32'(k);
            if (we) ref_mem[a[8:0]] = wdata[8*k +: 8];
            else val[8*k +: 8] = ref_mem[a[8:0]];
        end
        if (!we) begin
            case (nbytes)
                1:       exp_rdata = (uns || val < 32'd128)   ? val : val - 32'd256;
                2:       exp_rdata = (uns || val < 32'd32768) ? val : val - 32'd65536;
                default: exp_rdata = val;
            endcase
        end
    endtask

    // Issue one request from IDLE and check every beat plus the response at exact cycle offsets.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        beat_t b;
        model(we, size, uns, addr, wdata);
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);
        check("idle_mem_we", 32'(mem_we), 32'd0);
        check("rdata_hold", resp_rdata, last_rdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int k = 0; k < exp_beats.size(); k++) begin
            @(negedge clk);
            b = exp_beats[k];
            check("beat_resp_valid", 32'(resp_valid), 32'd0);
            check("beat_ready", 32'(req_ready), 32'd0);
            check("beat_we", 32'(mem_we), 32'(we));
            check("beat_byte_op", 32'(mem_byte_op), 32'(b.byte_op));
            check("beat_addr", mem_addr, b.addr);
            if (we) check("beat_wd", mem_wd, b.wd);
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("done_valid", 32'(resp_valid), 32'd1);
        check("done_rdata", resp_rdata, exp_rdata);
        check("done_err", 32'(resp_err), 32'(exp_err));
        check("done_ready", 32'(req_ready), 32'd0);
        check("done_mem_we", 32'(mem_we), 32'd0);
        last_rdata = exp_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  rs_size;
        logic [31:0] rs_addr;
        logic [31:0] rs_data;
        int          rs_n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_byte_op", 32'(mem_byte_op), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        rst = 1'b0;

        // Preload 0x0FF..0x103 = AA,11,22,83,F4 through the unit itself.
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hF483_2211);
        run_req(1'b1, 2'b00, 1'b0, 32'h0000_00FF, 32'h0000_00AA);

        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        check("lw_literal", resp_rdata, 32'hF483_2211);
        run_req(1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0);
        check("lb_literal", resp_rdata, 32'hFFFF_FF83);
        run_req(1'b0, 2'b00, 1'b1, 32'h0000_0102, 32'h0);
        check("lbu_literal", resp_rdata, 32'h0000_0083);
        run_req(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0);
        check("lh_literal", resp_rdata, 32'hFFFF_F483);
        run_req(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0);
        check("lhu_literal", resp_rdata, 32'h0000_F483);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_00FF, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_mis_err", 32'(resp_err), 32'd1);
        check("lw_mis_rdata", resp_rdata, 32'd0);
`else
        check("lw_mis_literal", resp_rdata, 32'h8322_11AA);
`endif
        run_req(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0000_BEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
`ifndef LSU_MISALIGN_TRAP_EN
        check("lw_after_sh_literal", resp_rdata, 32'hF4BE_EF11);
`endif
        run_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0102_0304);
        run_req(1'b0, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0);

        // Reset in the middle of a multi-beat store: issued beats land, the rest never happen.
`ifdef LSU_MISALIGN_TRAP_EN
        rs_size = 2'b01; rs_addr = 32'h0000_0142; rs_n = 2;
`else
        rs_size = 2'b10; rs_addr = 32'h0000_0141; rs_n = 3;
`endif
        rs_data = 32'hA1B2_C3D4;
        @(negedge clk);
        check("rs_idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_size = rs_size; req_unsigned = 1'b0;
        req_addr = rs_addr; req_wdata = rs_data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < rs_n; k++) begin
            @(negedge clk);
            check("rs_beat_we", 32'(mem_we), 32'd1);
            check("rs_beat_addr", mem_addr, rs_addr + 32'(k));
            check("rs_beat_wd", mem_wd, 32'(rs_data[8*k +: 8]));
            ref_mem[9'(rs_addr + 32'(k))] = rs_data[8*k +: 8];
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_rdata = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rs_after_ready", 32'(req_ready), 32'd1);
            check("rs_after_resp_valid", 32'(resp_valid), 32'd0);
            check("rs_after_mem_we", 32'(mem_we), 32'd0);
            check("rs_after_rdata", resp_rdata, 32'd0);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0140, 32'h0);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0144, 32'h0);

        for (int i = 0; i < 200; i++) begin
            run_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
